// File: rtl/mmm_pkg.sv
// Shared constants and helpers for the Montgomery multiplier datapath.
package mmm_pkg;
  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_LO   = 2'b01;
  localparam logic [1:0] MODE_HI   = 2'b10;
  localparam int         STAGES    = 4;

  function automatic int cdiv(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Products two tiles apart along the wider tile axis never overlap, so each
  // row collects one tile of the narrow axis and one parity of the wide axis.
  function automatic int row_idx(input int i, input int j, input bit by_b);
    return by_b ? (2 * j + (i % 2)) : (2 * i + (j % 2));
  endfunction
endpackage

// File: rtl/mmm_mul_pipe_if.sv
// Operation/result handshake bundle between the MMM sequencer and the multiplier.
interface mmm_mul_pipe_if #(
  parameter int IDW  = 90,
  parameter int TAGW = 4
);
  localparam int ODW = 2 * IDW;

  logic            i_valid;
  logic            o_ready;
  logic [IDW-1:0]  i_a;
  logic [IDW-1:0]  i_b;
  logic [1:0]      i_mode;
  logic [TAGW-1:0] i_tag;
  logic            o_valid;
  logic            i_ready;
  logic [ODW-1:0]  o_res;
  logic [TAGW-1:0] o_tag;
  logic            o_busy;

  modport master (
    output i_valid, i_a, i_b, i_mode, i_tag, i_ready,
    input  o_ready, o_valid, o_res, o_tag, o_busy
  );

  modport slave (
    input  i_valid, i_a, i_b, i_mode, i_tag, i_ready,
    output o_ready, o_valid, o_res, o_tag, o_busy
  );
endinterface

// File: rtl/mmm_pp_array.sv
// Stage 1 operand registers and stage 2 tiled partial-product registers.
module mmm_pp_array
  import mmm_pkg::*;
#(
  parameter int IDW = 90,
  parameter int TAW = 24,
  parameter int TBW = 16,
  localparam int NA = cdiv(IDW, TAW),
  localparam int NB = cdiv(IDW, TBW),
  localparam int PW = TAW + TBW
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_en1,
  input  logic                    i_en2,
  input  logic [IDW-1:0]          i_a,
  input  logic [IDW-1:0]          i_b,
  output logic [NA*NB-1:0][PW-1:0] o_pp
);
  logic [NA*TAW-1:0]         a_d, a_q;
  logic [NB*TBW-1:0]         b_d, b_q;
  logic [NA*NB-1:0][PW-1:0]  pp_d, pp_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (i_en1) begin
      a_d = (NA*TAW)'(i_a);
      b_d = (NB*TBW)'(i_b);
    end
  end

  always_comb begin
    pp_d = pp_q;
    if (i_en2) begin
      for (int i = 0; i < NA; i++)
        for (int j = 0; j < NB; j++)
          pp_d[i*NB+j] = PW'(a_q[i*TAW +: TAW]) * PW'(b_q[j*TBW +: TBW]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_q  <= '0;
      b_q  <= '0;
      pp_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      pp_q <= pp_d;
    end
  end

  assign o_pp = pp_q;
endmodule

// File: rtl/mmm_mul_pipe.sv
// Four-stage tiled unsigned multiplier with bubble-collapsing handshake and
// full/low/high result selection for the MMM sequencer.
module mmm_mul_pipe
  import mmm_pkg::*;
#(
  parameter int IDW  = 90,
  parameter int TAW  = 24,
  parameter int TBW  = 16,
  parameter int TAGW = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  mmm_mul_pipe_if.slave bus
);
  localparam int NA       = cdiv(IDW, TAW);
  localparam int NB       = cdiv(IDW, TBW);
  localparam int ODW      = 2 * IDW;
  localparam int PW       = TAW + TBW;
  localparam int RW       = ODW + 2;
  localparam bit ROW_BY_B = (TAW >= TBW);
  localparam int NROW     = ROW_BY_B ? 2 * NB : 2 * NA;

  typedef struct packed {
    logic [1:0]      mode;
    logic [TAGW-1:0] tag;
  } ctl_t;

  logic                      en1, en2, en3, en4;
  logic [STAGES:1]           en, vld_d, vld_q;
  ctl_t [STAGES:1]           ctl_d, ctl_q;
  logic [NA*NB-1:0][PW-1:0]  pp;
  logic [NROW-1:0][RW-1:0]   row_d, row_q;
  logic [RW-1:0]             sum;
  logic [ODW-1:0]            res_d, res_q;
  logic                      pipe_unused;

  // A stage may load when empty or when the stage ahead of it moves.
  assign en4 = !vld_q[4] || bus.i_ready;
  assign en3 = !vld_q[3] || en4;
  assign en2 = !vld_q[2] || en3;
  assign en1 = !vld_q[1] || en2;
  assign en  = {en4, en3, en2, en1};

  always_comb begin
    vld_d = vld_q;
    ctl_d = ctl_q;
    if (en[1]) begin
      vld_d[1]      = bus.i_valid;
      ctl_d[1].mode = bus.i_mode;
      ctl_d[1].tag  = bus.i_tag;
    end
    for (int k = 2; k <= STAGES; k++) begin
      if (en[k]) begin
        vld_d[k] = vld_q[k-1];
        ctl_d[k] = ctl_q[k-1];
      end
    end
  end

  mmm_pp_array #(
    .IDW (IDW),
    .TAW (TAW),
    .TBW (TBW)
  ) u_pp (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en1  (en[1]),
    .i_en2  (en[2]),
    .i_a    (bus.i_a),
    .i_b    (bus.i_b),
    .o_pp   (pp)
  );

  // Products within a row occupy disjoint bit ranges, so OR is exact.
  always_comb begin
    row_d = row_q;
    if (en[3]) begin
      row_d = '0;
      for (int i = 0; i < NA; i++)
        for (int j = 0; j < NB; j++)
          row_d[row_idx(i, j, ROW_BY_B)] = row_d[row_idx(i, j, ROW_BY_B)] |
                                           (RW'(pp[i*NB+j]) << (i*TAW + j*TBW));
    end
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < NROW; r++) sum = sum + row_q[r];
    res_d = res_q;
    if (en[4]) begin
      case (ctl_q[3].mode)
        MODE_LO: res_d = ODW'(sum[IDW-1:0]);
        MODE_HI: res_d = ODW'(sum[ODW-1:IDW]);
        default: res_d = sum[ODW-1:0];
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q <= '0;
      ctl_q <= '0;
      row_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      ctl_q <= ctl_d;
      row_q <= row_d;
      res_q <= res_d;
    end
  end

  // Product fits in ODW bits; the row guard bits and last-stage mode are not needed.
  assign pipe_unused = ^{sum[RW-1:ODW], ctl_q[4].mode};

  assign bus.o_ready = en[1];
  assign bus.o_valid = vld_q[4];
  assign bus.o_res   = res_q;
  assign bus.o_tag   = ctl_q[4].tag;
  assign bus.o_busy  = |vld_q;
endmodule

// File: tb/tb_mmm_mul_pipe.sv
// Scoreboard bench: 90-bit default instance for directed/streaming/backpressure/reset,
// 64-bit 16x16-tiled instance for long random traffic.
module tb_mmm_mul_pipe;
  import mmm_pkg::*;

  localparam int W0 = 90;
  localparam int W1 = 64;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mmm_mul_pipe_if #(.IDW(W0), .TAGW(TW)) bus0 ();
  mmm_mul_pipe_if #(.IDW(W1), .TAGW(TW)) bus1 ();

  mmm_mul_pipe #(.IDW(W0), .TAW(24), .TBW(16), .TAGW(TW)) dut0 (
    .i_clk (clk), .i_rstn (rstn), .bus (bus0));
  mmm_mul_pipe #(.IDW(W1), .TAW(16), .TBW(16), .TAGW(TW)) dut1 (
    .i_clk (clk), .i_rstn (rstn), .bus (bus1));

  typedef struct { logic [2*W0-1:0] res; logic [TW-1:0] tag; } exp0_t;
  typedef struct { logic [2*W1-1:0] res; logic [TW-1:0] tag; } exp1_t;

  exp0_t q0[$];
  exp1_t q1[$];
  exp0_t e0;
  exp1_t e1;
  int errs = 0, checks = 0, cyc = 0;
  int out_cnt0 = 0, out_cnt1 = 0, acc_cnt0 = 0, acc_cnt1 = 0;
  int acc_cyc0[$], out_cyc0[$];
  logic [2*W0-1:0] out_res0[$];
  logic [TW-1:0]   out_tag0[$];
  logic            hold_pend0 = 1'b0;
  logic [2*W0-1:0] hold_res0;
  logic [TW-1:0]   hold_tag0;
  bit              bp_done, drv1_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W0-1:0] model0(input logic [W0-1:0] a, input logic [W0-1:0] b,
                                             input logic [1:0] m);
    logic [2*W0-1:0] p, hi;
    p  = (2*W0)'(a) * (2*W0)'(b);
    hi = p >> W0;
    if (m == 2'd1) return p - (hi << W0);
    if (m == 2'd2) return hi;
    return p;
  endfunction

  function automatic logic [2*W1-1:0] model1(input logic [W1-1:0] a, input logic [W1-1:0] b,
                                             input logic [1:0] m);
    logic [2*W1-1:0] p, hi;
    p  = (2*W1)'(a) * (2*W1)'(b);
    hi = p >> W1;
    if (m == 2'd1) return p - (hi << W1);
    if (m == 2'd2) return hi;
    return p;
  endfunction

  function automatic logic [W0-1:0] rnd0();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      default: return t[W0-1:0];
    endcase
  endfunction

  function automatic logic [W1-1:0] rnd1();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      default: return t;
    endcase
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue0(input logic [W0-1:0] a, input logic [W0-1:0] b,
                        input logic [1:0] m, input logic [TW-1:0] t);
    bit done = 0;
    bus0.i_valid = 1'b1; bus0.i_a = a; bus0.i_b = b; bus0.i_mode = m; bus0.i_tag = t;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus0.o_ready) begin
        @(posedge clk);
        e0.res = model0(a, b, m); e0.tag = t;
        q0.push_back(e0);
        acc_cnt0++;
        #1;
        acc_cyc0.push_back(cyc);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus0.i_valid = 1'b0;
    if (!done) begin
      checks++; errs++;
      $display("FAIL dut0 accept timeout tag=%0d", t);
    end
  endtask

  task automatic issue1(input logic [W1-1:0] a, input logic [W1-1:0] b,
                        input logic [1:0] m, input logic [TW-1:0] t);
    bit done = 0;
    bus1.i_valid = 1'b1; bus1.i_a = a; bus1.i_b = b; bus1.i_mode = m; bus1.i_tag = t;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus1.o_ready) begin
        @(posedge clk);
        e1.res = model1(a, b, m); e1.tag = t;
        q1.push_back(e1);
        acc_cnt1++;
        #1;
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus1.i_valid = 1'b0;
    if (!done) begin
      checks++; errs++;
      $display("FAIL dut1 accept timeout tag=%0d", t);
    end
  endtask

  task automatic drain0();
    for (int n = 0; n < 200 && q0.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("dut0 drained", q0.size(), 0);
  endtask

  // Result monitors: a transfer happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rstn && bus0.o_valid && bus0.i_ready) begin
      out_cnt0++;
      out_cyc0.push_back(cyc);
      out_res0.push_back(bus0.o_res);
      out_tag0.push_back(bus0.o_tag);
      if (q0.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut0 unexpected result tag=%0d res=%0h", bus0.o_tag, bus0.o_res);
      end else begin
        e0 = q0.pop_front();
        check("dut0 res", bus0.o_res, e0.res);
        check("dut0 tag", bus0.o_tag, e0.tag);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus1.o_valid && bus1.i_ready) begin
      out_cnt1++;
      if (q1.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut1 unexpected result tag=%0d res=%0h", bus1.o_tag, bus1.o_res);
      end else begin
        e1 = q1.pop_front();
        check("dut1 res", bus1.o_res, e1.res);
        check("dut1 tag", bus1.o_tag, e1.tag);
      end
    end
  end

  // A stalled result must stay put until it is taken.
  always @(negedge clk) begin
    if (rstn && hold_pend0) begin
      check("hold valid", bus0.o_valid, 1);
      check("hold res", bus0.o_res, hold_res0);
      check("hold tag", bus0.o_tag, hold_tag0);
    end
    hold_pend0 = rstn && bus0.o_valid && !bus0.i_ready;
    hold_res0  = bus0.o_res;
    hold_tag0  = bus0.o_tag;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W0-1:0]  ones, a2, b2;
    logic [191:0]   kfull;
    int             base_out, base_acc, vcount;

    bus0.i_valid = 0; bus0.i_a = '0; bus0.i_b = '0; bus0.i_mode = '0; bus0.i_tag = '0;
    bus0.i_ready = 1;
    bus1.i_valid = 0; bus1.i_a = '0; bus1.i_b = '0; bus1.i_mode = '0; bus1.i_tag = '0;
    bus1.i_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst o_valid", bus0.o_valid, 0);
    check("rst o_res", bus0.o_res, 0);
    check("rst o_tag", bus0.o_tag, 0);
    check("rst o_busy", bus0.o_busy, 0);
    check("rst o_ready", bus0.o_ready, 1);
    check("rst dut1 o_valid", bus1.o_valid, 0);
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;

    // Full product of all-ones operands, result visible 3 edges after accept
    ones = '1;
    acc_cyc0.delete(); out_cyc0.delete(); out_res0.delete(); out_tag0.delete();
    issue0(ones, ones, MODE_FULL, 4'd3);
    drain0();
    kfull = (192'd1 << 180) - (192'd1 << 91) + 192'd1;
    check("full count", out_res0.size(), 1);
    if (out_res0.size() == 1) begin
      check("full const", out_res0[0], kfull);
      check("full tag", out_tag0[0], 3);
      check("full latency", out_cyc0[0] - acc_cyc0[0], 3);
    end

    // Modes back to back, plus mode 3 aliasing full
    a2 = '0; a2[89] = 1'b1;
    b2 = 90'd3;
    out_res0.delete(); out_tag0.delete();
    issue0(a2, b2, 2'd0, 4'd0);
    issue0(a2, b2, 2'd1, 4'd1);
    issue0(a2, b2, 2'd2, 4'd2);
    issue0(a2, b2, 2'd3, 4'd5);
    drain0();
    check("mode count", out_res0.size(), 4);
    if (out_res0.size() == 4) begin
      check("mode full", out_res0[0], 192'd3 << 89);
      check("mode lo", out_res0[1], 192'd1 << 89);
      check("mode hi", out_res0[2], 1);
      check("mode 11", out_res0[3], 192'd3 << 89);
      for (int i = 0; i < 3; i++) check("mode order", out_tag0[i], i);
    end

    // Streaming: 8 back-to-back operations, 8 consecutive results
    acc_cyc0.delete(); out_cyc0.delete(); out_tag0.delete();
    for (int k = 0; k < 8; k++)
      issue0(rnd0(), rnd0(), 2'($urandom_range(0, 3)), TW'(k));
    drain0();
    check("stream count", out_cyc0.size(), 8);
    if (out_cyc0.size() == 8 && acc_cyc0.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("stream cycle", out_cyc0[i], acc_cyc0[0] + 3 + i);
        check("stream tag", out_tag0[i], i);
      end
    end

    // Backpressure: only four operations fit while the sink is stalled
    bus0.i_ready = 0;
    out_tag0.delete();
    base_out = out_cnt0; base_acc = acc_cnt0;
    bp_done = 0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          issue0(rnd0(), rnd0(), 2'($urandom_range(0, 3)), TW'(k));
        bp_done = 1;
      end
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp o_ready", bus0.o_ready, 0);
    check("bp accepted", acc_cnt0 - base_acc, 4);
    check("bp no output", out_cnt0 - base_out, 0);
    check("bp o_valid", bus0.o_valid, 1);
    check("bp o_busy", bus0.o_busy, 1);
    @(posedge clk); #1 bus0.i_ready = 1;
    for (int n = 0; n < 200 && !bp_done; n++) @(posedge clk);
    #1;
    check("bp issue done", bp_done, 1);
    drain0();
    check("bp outputs", out_cnt0 - base_out, 6);
    check("bp tag count", out_tag0.size(), 6);
    if (out_tag0.size() == 6)
      for (int i = 0; i < 6; i++) check("bp order", out_tag0[i], i);

    // Reset with three operations in flight
    bus0.i_ready = 0;
    for (int k = 0; k < 3; k++) issue0(rnd0(), rnd0(), MODE_FULL, TW'(k));
    repeat (2) @(posedge clk);
    #1;
    check("pre-rst o_valid", bus0.o_valid, 1);
    check("pre-rst o_busy", bus0.o_busy, 1);
    #2 rstn = 0;
    #1;
    check("rst async o_valid", bus0.o_valid, 0);
    check("rst async o_busy", bus0.o_busy, 0);
    check("rst async o_res", bus0.o_res, 0);
    q0.delete();
    @(posedge clk); #1 rstn = 1; bus0.i_ready = 1;
    base_out = out_cnt0;
    vcount = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus0.o_valid) vcount++;
    end
    @(posedge clk); #1;
    check("post-rst valid cycles", vcount, 0);
    check("post-rst outputs", out_cnt0 - base_out, 0);

    // 64-bit, 16x16 tiles: random traffic both sides
    drv1_done = 0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          issue1(rnd1(), rnd1(), 2'($urandom_range(0, 3)), TW'(k));
        end
        drv1_done = 1;
      end
      begin
        while (!drv1_done) begin
          @(posedge clk); #1;
          bus1.i_ready = ($urandom_range(0, 3) != 0);
        end
        bus1.i_ready = 1;
      end
    join
    for (int n = 0; n < 200 && q1.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("dut1 accepted", acc_cnt1, 1000);
    check("dut1 outputs", out_cnt1, 1000);
    check("dut1 drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
